// File: rtl/seg7_scan.sv
// Eight-digit multiplexed hex display driver.
// The value on `digit` is latched only at frame boundaries, so the display never shows a half-updated frame.
module seg7_scan #(
    parameter int unsigned SCAN_DIV = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] digit,
    input  logic        en,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [7:0]    an_d, seg_d;
    logic          frame_done_d;
    logic          wrap;
    logic [3:0]    nibble;
    logic [7:0]    seg_dec;

    always_comb begin
        wrap         = (cnt_q == CNT_MAX);
        cnt_d        = wrap ? '0 : cnt_q + 1'b1;
        idx_d        = wrap ? idx_q + 3'd1 : idx_q;
        frame_done_d = wrap && (idx_q == 3'd7);
        shadow_d     = frame_done_d ? digit : shadow_q;
        nibble       = shadow_q[{idx_q, 2'b00} +: 4];
    end

    // Active-low segments {dp,g,f,e,d,c,b,a}; dp held off.
    always_comb begin
        seg_dec = 8'hFF;
        case (nibble)
            4'h0: seg_dec = 8'hC0;
            4'h1: seg_dec = 8'hF9;
            4'h2: seg_dec = 8'hA4;
            4'h3: seg_dec = 8'hB0;
            4'h4: seg_dec = 8'h99;
            4'h5: seg_dec = 8'h92;
            4'h6: seg_dec = 8'h82;
            4'h7: seg_dec = 8'hF8;
            4'h8: seg_dec = 8'h80;
            4'h9: seg_dec = 8'h90;
            4'hA: seg_dec = 8'h88;
            4'hB: seg_dec = 8'h83;
            4'hC: seg_dec = 8'hC6;
            4'hD: seg_dec = 8'hA1;
            4'hE: seg_dec = 8'h86;
            4'hF: seg_dec = 8'h8E;
            default: seg_dec = 8'hFF;
        endcase
    end

    // Blanking only gates the outputs; the scan keeps running underneath.
    always_comb begin
        an_d  = en ? ~(8'b1 << idx_q) : 8'hFF;
        seg_d = en ? seg_dec : 8'hFF;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            shadow_q   <= 32'h0;
            an         <= 8'hFF;
            seg        <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            an         <= an_d;
            seg        <= seg_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with SCAN_DIV=4 (one frame = 32 cycles).
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] digit;
    logic        en;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] an_tab [0:7];
    logic [7:0] exp_tab [0:5][0:7];

    seg7_scan #(
        .SCAN_DIV(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digit      (digit),
        .en         (en),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic fill_row(input int f, input logic [31:0] segs_lo, input logic [31:0] segs_hi);
        for (int j = 0; j < 4; j++) begin
            exp_tab[f][j]     = segs_lo[8*j +: 8];
            exp_tab[f][j + 4] = segs_hi[8*j +: 8];
        end
    endtask

    // Edge k (1-based after reset release) shows idx ((k-1)%32)/4 of frame (k-1)/32.
    task automatic run_scan(input int kmax, input int phase);
        logic       en_at;
        logic [7:0] e_an;
        logic [7:0] e_seg;
        int         f;
        int         j;
        for (int k = 1; k <= kmax; k++) begin
            en_at = en;
            @(posedge clk);
            #1;
            f     = (k - 1) / 32;
            j     = ((k - 1) % 32) / 4;
            e_an  = en_at ? an_tab[j] : 8'hFF;
            e_seg = en_at ? exp_tab[f][j] : 8'hFF;
            check($sformatf("an k=%0d", k), an, e_an);
            check($sformatf("seg k=%0d", k), seg, e_seg);
            check($sformatf("frame_done k=%0d", k), {7'd0, frame_done},
                  {7'd0, (k % 32) == 0});
            if (phase == 0) begin
                if (k == 40)  digit = 32'h0000_0000;
                if (k == 80)  digit = 32'h1111_1111;
                if (k == 137) en = 1'b0;
                if (k == 143) en = 1'b1;
            end else begin
                if (k == 31) digit = 32'h7654_3210;
                if (k == 32) digit = 32'hFFFF_FFFF;
            end
        end
    endtask

    initial begin
        an_tab[0] = 8'hFE; an_tab[1] = 8'hFD; an_tab[2] = 8'hFB; an_tab[3] = 8'hF7;
        an_tab[4] = 8'hEF; an_tab[5] = 8'hDF; an_tab[6] = 8'hBF; an_tab[7] = 8'h7F;

        // Scan-phase shadows: 0, 89ABCDEF, 0, then 11111111 for three frames.
        fill_row(0, 32'hC0C0_C0C0, 32'hC0C0_C0C0);
        fill_row(1, 32'hC6A1_868E, 32'h8090_8883);
        fill_row(2, 32'hC0C0_C0C0, 32'hC0C0_C0C0);
        fill_row(3, 32'hF9F9_F9F9, 32'hF9F9_F9F9);
        fill_row(4, 32'hF9F9_F9F9, 32'hF9F9_F9F9);
        fill_row(5, 32'hF9F9_F9F9, 32'hF9F9_F9F9);

        rst   = 1'b1;
        en    = 1'b0;
        digit = 32'h0;
        #1 rst = 1'b0;
        #1;
        check("reset an", an, 8'hFF);
        check("reset seg", seg, 8'hFF);
        check("reset frame_done", {7'd0, frame_done}, 8'h00);

        @(negedge clk);
        en    = 1'b1;
        digit = 32'h89AB_CDEF;
        @(negedge clk);
        rst = 1'b1;

        run_scan(182, 0);

        // Mid-scan async reset during idx5, well clear of any clock edge.
        #2 rst = 1'b0;
        #1;
        check("async reset an", an, 8'hFF);
        check("async reset seg", seg, 8'hFF);
        check("async reset frame_done", {7'd0, frame_done}, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Boundary-edge capture: 76543210 is only valid at the frame edge itself.
        fill_row(0, 32'hC0C0_C0C0, 32'hC0C0_C0C0);
        fill_row(1, 32'hB0A4_F9C0, 32'hF882_9299);
        run_scan(64, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Downstream consumer of the 32-bit `digit` register that the memory-mapped I/O bus decoder exposes at address 0xF000.
- Time-multiplexes eight hex nibbles onto a common 8-digit seven-segment display: one anode active at a time, segments decoded from the matching nibble.
- Captures `digit` into a shadow register only at frame boundaries, so a CPU write never shows up as a partly updated frame.

Parameters:
- SCAN_DIV, 200000, clock cycles each digit stays lit; legal range >= 2; counter width = clog2(SCAN_DIV).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- digit  input  32  display value from the I/O bus digit register; nibble k = digit[4k+3:4k]
- en  input  1  display enable; 0 blanks all outputs
- an  output  8  anode enables, active-low, one-hot-zero while scanning
- seg  output  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}
- frame_done  output  1  one-cycle pulse when the shadow register reloads

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - cnt=0, idx=0, shadow=0
  - an=8'hFF, seg=8'hFF, frame_done=0
- cnt, the divider:
  - Increments every cycle.
  - At cnt==SCAN_DIV-1, cnt wraps to 0 and idx advances by 1, wrapping 7->0.
  - Runs regardless of en.
- Frame boundary (cnt==SCAN_DIV-1 and idx==7), on that clock edge:
  - shadow <= digit
  - frame_done <= 1
  - idx -> 0
- frame_done is 0 on every other cycle.
- Full frame = 8*SCAN_DIV cycles; frame_done period is exactly 8*SCAN_DIV.
- an and seg are registered, updated every cycle:
  - en=1: an <= ~(8'b1 << idx); seg <= decode(shadow[4*idx+3 : 4*idx]).
  - en=0: an <= 8'hFF, seg <= 8'hFF.
  - Latency: one cycle from an idx, shadow or en change to the outputs.
- decode table (dp always off, bit7=1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- digit changes mid-frame: no effect on an/seg until the next frame boundary.
- digit changes on the boundary edge itself: the value sampled at that edge is captured.
- Reset mid-frame: outputs blank immediately.
  - After rst deasserts, the first clock edge gives an=FE, seg=C0 with en=1.
  - shadow stays 0 until the first boundary.
- en toggling: affects outputs only.
  - The scan position is not reset.
  - On re-enable, the display resumes at the current idx.
- idx values 0..7 only; no illegal states are reachable.

Test Plan:
- Reset: SCAN_DIV=4, drive rst=0 with no clock -> an=FF, seg=FF, frame_done=0. Release with en=1; first edge -> an=FE, seg=C0.
- Frame capture: SCAN_DIV=4, digit=32'h89ABCDEF held.
  - frame_done pulses exactly at cycle 32 after reset release, and every 32 cycles after that.
  - In the next frame: idx0 -> an=FE, seg=8E; idx3 -> an=F7, seg=C6; idx7 -> an=7F, seg=80.
  - Each idx holds for 4 cycles.
- Tearing guard: mid-frame, change digit from 32'h00000000 to 32'h11111111.
  - seg stays C0 on all anodes until the boundary.
  - Next frame -> seg=F9 on every digit.
- Blanking: deassert en during idx2 -> next cycle an=FF, seg=FF.
  - Reassert en 6 cycles later -> an/seg resume at the idx given by the free-running counter.
  - frame_done timing is unchanged.
- Async reset mid-scan: assert rst=0 between clock edges during idx5.
  - an=FF and seg=FF immediately, with no clock edge.
  - After release, the idx0 sequence restarts and shadow=0 (seg=C0).
- Boundary-edge write: change digit to 32'h76543210 on the same edge where cnt==3 and idx==7.
  - frame_done=1 for one cycle.
  - Next frame idx0 -> seg=C0, idx1 -> seg=F9, idx6 -> seg=82, idx7 -> seg=F8.
